// File: rtl/core_fetch_pkg.sv
// Shared types for the 0dMIPS instruction-fetch stage.
package core_fetch_pkg;

  typedef enum logic [1:0] {
    F_IDLE,
    F_WAIT,
    F_DROP
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [63:0] pc;
  } IF_regs_t;

  localparam logic [63:0] RESET_PC = '0;
  localparam logic [63:0] PC_STEP  = 64'd4;

  // Saturating 32-bit increment used by the performance counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
    return (en && value != '1) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} buffer absorbing a fetch response while ID is stalled.
// clear has priority over load, load over drain.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [63:0] load_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [63:0] pc
);

  // Capture a parked response; release it on drain or drop it on flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/core_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding imem
// request at a time and fills the IF/ID register, with a 1-entry skid buffer.
// Optional macro CORE_FETCH_PERF_EN enables saturating performance counters;
// otherwise the counter ports are tied to zero.
module core_fetch
  import core_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] next_pc,
  input  logic        flush,
  input  logic        stall,
  output logic [63:0] pc,
  output logic [63:0] pc4,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_killed,
  output logic [31:0] perf_stall_cyc
);

  fetch_state_t state;
  IF_regs_t     if_regs;

  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [63:0] skid_pc;

  logic resp;
  logic deliver;
  logic to_ifid;
  logic to_skid;
  logic drain;

  assign resp    = (state == F_WAIT) & imem_rvalid;
  assign deliver = resp & ~flush;
  assign to_ifid = deliver & (~if_regs.valid | ~stall);
  assign to_skid = deliver & if_regs.valid & stall;
  // A full skid blocks new requests, so a drain never coincides with a response.
  assign drain   = skid_valid & ~stall & ~flush;

  assign imem_req  = (state == F_IDLE) & ~flush & ~skid_valid;
  assign imem_addr = pc;
  assign pc4       = pc + PC_STEP;

  assign if_valid = if_regs.valid;
  assign if_instr = if_regs.instr;
  assign if_pc    = if_regs.pc;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (to_skid),
    .drain      (drain),
    .clear      (flush),
    .load_instr (imem_rdata),
    .load_pc    (pc),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // Request FSM and architectural PC; flush redirects and kills in-flight work.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= F_IDLE;
      pc    <= RESET_PC;
    end else if (flush) begin
      pc <= next_pc;
      case (state)
        F_WAIT, F_DROP: state <= imem_rvalid ? F_IDLE : F_DROP;
        default:        state <= F_IDLE;
      endcase
    end else begin
      case (state)
        F_IDLE: begin
          if (imem_req && imem_ready) state <= F_WAIT;
        end
        F_WAIT: begin
          if (imem_rvalid) begin
            pc    <= next_pc;
            state <= F_IDLE;
          end
        end
        F_DROP: begin
          if (imem_rvalid) state <= F_IDLE;
        end
        default: state <= F_IDLE;
      endcase
    end
  end

  // IF/ID register: skid contents take precedence, then a fresh response.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_regs <= '0;
    end else if (flush) begin
      if_regs.valid <= 1'b0;
    end else if (drain) begin
      if_regs <= '{valid: 1'b1, instr: skid_instr, pc: skid_pc};
    end else if (to_ifid) begin
      if_regs <= '{valid: 1'b1, instr: imem_rdata, pc: pc};
    end else if (!stall) begin
      if_regs.valid <= 1'b0;
    end
  end

`ifdef CORE_FETCH_PERF_EN
  logic kill;
  assign kill = imem_rvalid & ((state == F_DROP) | ((state == F_WAIT) & flush));

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched   <= '0;
      perf_killed    <= '0;
      perf_stall_cyc <= '0;
    end else begin
      perf_fetched   <= sat_inc(perf_fetched, deliver);
      perf_killed    <= sat_inc(perf_killed, kill);
      perf_stall_cyc <= sat_inc(perf_stall_cyc, stall & if_regs.valid);
    end
  end
`else
  assign perf_fetched   = '0;
  assign perf_killed    = '0;
  assign perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_core_fetch.sv
// Randomized bench for core_fetch against a transaction-level model: an
// in-order queue of delivered words, a model PC and a memory with latency.
module tb_core_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] next_pc;
  logic        flush;
  logic        stall;
  logic [63:0] pc;
  logic [63:0] pc4;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic [31:0] perf_fetched;
  logic [31:0] perf_killed;
  logic [31:0] perf_stall_cyc;

  always #5 clk = ~clk;

  core_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .next_pc        (next_pc),
    .flush          (flush),
    .stall          (stall),
    .pc             (pc),
    .pc4            (pc4),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .perf_fetched   (perf_fetched),
    .perf_killed    (perf_killed),
    .perf_stall_cyc (perf_stall_cyc)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } word_t;

  // Reference model
  word_t       q[$];
  logic [63:0] m_pc;
  bit          m_out;
  bit          m_killed;
  int          m_cnt;
  int unsigned m_fetched, m_kills, m_stall_cyc;
  bit          stale;

  // Stimulus knobs (percent)
  int p_stall, p_flush, p_ready, p_jump, max_lat;

  task automatic model_reset();
    q.delete();
    m_pc        = '0;
    m_out       = 0;
    m_killed    = 0;
    m_cnt       = 0;
    m_fetched   = 0;
    m_kills     = 0;
    m_stall_cyc = 0;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    flush       = 1'b0;
    stall       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    next_pc     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_eq("rst_if_instr", if_instr, 0);
    check_eq("rst_if_pc", if_pc, 0);
    check_eq("rst_if_valid", if_valid, 0);
    check_eq("rst_pc", pc, 0);
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic step(input bit force_flush = 0, input logic [63:0] force_pc = '0);
    bit exp_req;
    reset      = 1'b0;
    stall      = ($urandom_range(99) < p_stall);
    flush      = ($urandom_range(99) < p_flush);
    imem_ready = ($urandom_range(99) < p_ready);
    if ($urandom_range(99) < p_jump) next_pc = {$urandom, $urandom} & ~64'h3;
    else next_pc = m_pc + 64'd4;
    if (force_flush) begin
      flush   = 1'b1;
      next_pc = force_pc;
    end
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (m_out) begin
      m_cnt--;
      if (m_cnt == 0) imem_rvalid = 1'b1;
    end
    if (stale) begin
      imem_rvalid = 1'b1;
      imem_ready  = 1'b0;
      flush       = 1'b0;
      stale       = 0;
    end
    #4;
    exp_req = !m_out && !flush && (q.size() < 2);
    check_eq("pc", pc, m_pc);
    check_eq("pc4", pc4, m_pc + 64'd4);
    check_eq("imem_req", imem_req, exp_req);
    if (exp_req) check_eq("imem_addr", imem_addr, m_pc);
    check_eq("if_valid", if_valid, q.size() > 0);
    if (q.size() > 0) begin
      check_eq("if_pc", if_pc, q[0].pc);
      check_eq("if_instr", if_instr, q[0].instr);
    end
`ifdef CORE_FETCH_PERF_EN
    check_eq("perf_fetched", perf_fetched, m_fetched);
    check_eq("perf_killed", perf_killed, m_kills);
    check_eq("perf_stall_cyc", perf_stall_cyc, m_stall_cyc);
`else
    check_eq("perf_fetched", perf_fetched, 0);
    check_eq("perf_killed", perf_killed, 0);
    check_eq("perf_stall_cyc", perf_stall_cyc, 0);
`endif
    // Advance model at the clock edge.
    if (stall && q.size() > 0) m_stall_cyc++;
    if (!stall && q.size() > 0) void'(q.pop_front());
    if (imem_rvalid && m_out) begin
      m_out = 0;
      if (flush || m_killed) m_kills++;
      else begin
        q.push_back('{pc: m_pc, instr: imem_rdata});
        m_fetched++;
        m_pc = next_pc;
      end
    end
    if (flush) begin
      q.delete();
      m_pc = next_pc;
      if (m_out) m_killed = 1;
    end
    if (exp_req && imem_ready) begin
      m_out    = 1;
      m_killed = 0;
      m_cnt    = $urandom_range(max_lat, 1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    stale = 0;
    do_reset();

    // Sequential fetch, ready always, 1-cycle latency, no stall.
    p_stall = 0; p_flush = 0; p_ready = 100; p_jump = 0; max_lat = 1;
    repeat (12) step();

    // Stall bursts fill the skid buffer.
    p_stall = 70;
    repeat (60) step();

    // PC wrap-around: pc4 of the top word is zero.
    p_stall = 0;
    step(1, 64'hFFFF_FFFF_FFFF_FFFC);
    repeat (8) step();

    // Redirects to 0x400 with longer latency exercise the drop path.
    max_lat = 4;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_out) step(1, 64'h400);
    end

    // Mixed random traffic.
    p_stall = 30; p_flush = 8; p_ready = 70; p_jump = 5; max_lat = 4;
    repeat (3000) step();

    // Reset while a request is outstanding; the late response must be ignored.
    p_flush = 0; p_ready = 100; max_lat = 4;
    for (int i = 0; i < 50 && !m_out; i++) step();
    check_eq("outstanding_before_reset", m_out, 1);
    do_reset();
    stale = 1;
    p_stall = 0;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
